tt_sweep_checker: RTL and testbench
===================================

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2: clock cycles each input vector is held before the output is sampled, legal range 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request one 16-vector sweep; SHALL be sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running sweep.
REQ-006 expected  input  16  target truth table, latched on an accepted start.
REQ-007 dut_in  output  4  vector to the 4-input gate; dut_in[3] drives _0 (MSB) ... dut_in[0] drives _3.
REQ-008 dut_out  input  1  gate output (_4), same clock domain, combinational from dut_in.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 tt_out  output  16  captured truth table.
REQ-012 match  output  1  tt_out equals latched expected; valid from done until the next accepted start.
REQ-013 fail_count  output  5  number of mismatching vectors, 0..16.
REQ-014 first_fail_idx  output  4  vector index of the first mismatch; 0 when there is none.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, SAMPLE and DONE.
REQ-016 IDLE with start=1 SHALL go to APPLY, set vector index i=0, latch expected, and clear tt_out, fail_count, first_fail_idx and match.
REQ-017 IDLE with start=0 SHALL stay in IDLE.
REQ-018 APPLY SHALL drive dut_in=i for exactly SETTLE cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle, keep dut_in=i, and perform tt_out <= {tt_out[14:0], dut_out}.
REQ-020 SAMPLE SHALL compare dut_out against expected[15-i].
REQ-021 On a mismatch, SAMPLE SHALL increment fail_count.
REQ-022 On the first mismatch of a sweep (fail_count was 0), SAMPLE SHALL set first_fail_idx=i.
REQ-023 SAMPLE with i<15 SHALL increment i and return to APPLY.
REQ-024 SAMPLE with i=15 SHALL go to DONE; i SHALL never wrap during a sweep.
REQ-025 DONE SHALL assert done for exactly one cycle, set match=(fail_count==0), and return to IDLE.
REQ-026 Sweep length SHALL be 16*(SETTLE+1) cycles, so done is high in cycle 16*(SETTLE+1)+1 after the accepting edge; this is 49 for SETTLE=2.
REQ-027 busy SHALL be high in APPLY, SAMPLE and DONE, and low in IDLE.
REQ-028 start SHALL be ignored outside IDLE; start held high SHALL begin a new sweep in the cycle after DONE.
REQ-029 abort in APPLY or SAMPLE SHALL go to IDLE next cycle with no done pulse and no capture in that cycle.
REQ-030 After an abort, partial tt_out and fail_count SHALL be held and match SHALL stay 0.
REQ-031 abort in IDLE or DONE SHALL be ignored.
REQ-032 abort and start high together in IDLE SHALL start a sweep.
REQ-033 dut_in SHALL be 4'b0000 in IDLE and DONE.
REQ-034 tt_out, fail_count, first_fail_idx and match SHALL hold their values in IDLE until the next accepted start.
REQ-035 The bit convention SHALL be: vector i maps to tt_out bit 15-i; a full sweep of the 0x7176 gate therefore yields tt_out=0x7176.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, with i, dut_in, busy, done, tt_out, match, fail_count, first_fail_idx and the latched expected all 0.
REQ-037 Reset in mid-sweep SHALL discard the sweep with no done pulse.
REQ-038 The first edge after rst_n deasserts SHALL behave as IDLE.

Verification
REQ-039 Gate 0x7176 model, SETTLE=2, expected=0x7176, 1-cycle start -> done in cycle 49, tt_out=0x7176, match=1, fail_count=0, first_fail_idx=0.
REQ-040 Same gate, expected=0x7177 -> tt_out=0x7176, match=0, fail_count=1, first_fail_idx=15.
REQ-041 Same gate, expected=0x8E89 -> fail_count=16, first_fail_idx=0, match=0.
REQ-042 start pulsed repeatedly while busy -> exactly one done; start held high -> back-to-back sweeps, IDLE lasting one cycle between them.
REQ-043 abort during the SAMPLE of i=6 -> busy low next cycle, no done, tt_out holds its 6 captured bits, match=0; next start runs a clean full sweep.
REQ-044 rst_n low during APPLY of i=9, asynchronous to clk -> all outputs 0 before the next edge; after release, start gives a normal 49-cycle sweep.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: drives all 16 vectors of a 4-input combinational gate,
// captures its output and compares the resulting truth table against an expected one.
module tt_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_out,
  output logic        match,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [3:0]  r_settle;
  logic [15:0] r_exp;
  logic [15:0] r_tt;
  logic [4:0]  r_fail;
  logic [3:0]  r_first;
  logic        r_match;

  logic        w_accept;
  logic        w_capture;
  logic        w_settled;
  logic        w_last;
  logic        w_mismatch;

  assign w_settled  = (r_settle == SETTLE_LAST);
  assign w_last     = (r_idx == 4'd15);
  assign w_mismatch = (dut_out != r_exp[4'd15 - r_idx]);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = APPLY;
          w_accept    = 1'b1;
        end
      end
      APPLY: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_settled) begin
          w_state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = w_last ? DONE : APPLY;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Settle counter restarts on every entry into APPLY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (r_state == APPLY && w_state_nxt == APPLY) begin
      r_settle <= r_settle + 4'd1;
    end else begin
      r_settle <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_exp <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      r_exp <= expected;
    end else if (w_capture && !w_last) begin
      r_idx <= r_idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tt    <= '0;
      r_fail  <= '0;
      r_first <= '0;
    end else if (w_accept) begin
      r_tt    <= '0;
      r_fail  <= '0;
      r_first <= '0;
    end else if (w_capture) begin
      r_tt <= {r_tt[14:0], dut_out};
      if (w_mismatch) begin
        r_fail <= r_fail + 5'd1;
        if (r_fail == 5'd0) begin
          r_first <= r_idx;
        end
      end
    end
  end

  // Match is resolved on the final sample so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match <= 1'b0;
    end else if (w_accept) begin
      r_match <= 1'b0;
    end else if (w_capture && w_last) begin
      r_match <= (r_fail == 5'd0) && !w_mismatch;
    end
  end

  always_comb begin
    dut_in         = '0;
    busy           = (r_state != IDLE);
    done           = (r_state == DONE);
    tt_out         = r_tt;
    match          = r_match;
    fail_count     = r_fail;
    first_fail_idx = r_first;
    if (r_state == APPLY || r_state == SAMPLE) begin
      dut_in = r_idx;
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: a truth-table gate model feeds dut_out, and every sweep
// result is predicted from the gate/expected tables with plain bit arithmetic.
module tb_tt_sweep_checker;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned SWEEP_LAT = 16 * (SETTLE + 1) + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic        busy;
  logic        done;
  logic [15:0] tt_out;
  logic        match;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;

  logic [15:0] gate_tt;
  int unsigned n_assert;
  int unsigned n_fail;

  tt_sweep_checker #(.SETTLE(SETTLE)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .expected       (expected),
    .dut_in         (dut_in),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .tt_out         (tt_out),
    .match          (match),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx)
  );

  // Gate model: input vector v (dut_in[3] is the MSB input) yields truth-table bit 15-v.
  assign dut_out = gate_tt[4'd15 - dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] first_mis(input logic [15:0] g, input logic [15:0] e,
                                           input int unsigned n);
    for (int unsigned v = 0; v < n; v++) begin
      if (g[15 - v] != e[15 - v]) return 4'(v);
    end
    return 4'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic [15:0] exp_tt, input string tag,
                       input bit abort_start, input bit abort_done);
    int unsigned cyc;
    int unsigned seq_err;
    logic [4:0]  m_fail;
    logic [3:0]  m_first;
    logic        m_match;
    m_fail  = 5'($countones(gate_tt ^ exp_tt));
    m_first = first_mis(gate_tt, exp_tt, 16);
    m_match = (gate_tt == exp_tt);
    start    = 1'b1;
    expected = exp_tt;
    abort    = abort_start;
    tick();
    start    = 1'b0;
    abort    = 1'b0;
    expected = ~exp_tt;
    check({tag, ".cleared"}, {11'd0, tt_out, fail_count, first_fail_idx, match, busy}, 32'd1);
    cyc     = 1;
    seq_err = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1 || dut_in !== 4'((cyc - 1) / (SETTLE + 1))) seq_err++;
      tick();
      cyc++;
    end
    check({tag, ".latency"}, cyc, SWEEP_LAT);
    check({tag, ".vector_seq"}, seq_err, 0);
    check({tag, ".tt_out"}, {16'd0, tt_out}, {16'd0, gate_tt});
    check({tag, ".fail_count"}, {27'd0, fail_count}, {27'd0, m_fail});
    check({tag, ".first_fail"}, {28'd0, first_fail_idx}, {28'd0, m_first});
    check({tag, ".match"}, {31'd0, match}, {31'd0, m_match});
    check({tag, ".done_busy_din"}, {26'd0, busy, dut_in, 1'b0}, {26'd0, 1'b1, 4'd0, 1'b0});
    abort = abort_done;
    tick();
    abort = 1'b0;
    check({tag, ".after_done"}, {30'd0, done, busy}, 32'd0);
    check({tag, ".held"}, {6'd0, tt_out, fail_count, first_fail_idx, match},
          {6'd0, gate_tt, m_fail, m_first, m_match});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    int unsigned n_done;
    int unsigned target;
    logic [15:0] e;
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = '0;
    gate_tt  = 16'h7176;

    repeat (3) @(posedge clk);
    #1;
    check("reset.outputs", {busy, done, dut_in, tt_out, match, fail_count, first_fail_idx}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("reset.idle_after_release", {30'd0, busy, done}, 32'd0);

    sweep(16'h7176, "pass", 1'b0, 1'b0);
    sweep(16'h7177, "lsb", 1'b0, 1'b0);
    sweep(16'h8E89, "inverse", 1'b0, 1'b0);
    sweep(16'h7176, "abort_ignored", 1'b1, 1'b1);

    for (int unsigned k = 0; k < 6; k++) begin
      gate_tt = 16'($urandom);
      case (k % 3)
        0: e = gate_tt;
        1: e = gate_tt ^ (16'd1 << $urandom_range(15, 0));
        default: e = 16'($urandom);
      endcase
      sweep(e, $sformatf("rand%0d", k), 1'b0, 1'b0);
    end

    // start pulsed while busy: only one sweep
    gate_tt  = 16'h7176;
    start    = 1'b1;
    expected = 16'h7176;
    tick();
    start  = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 70; c++) begin
      if (done === 1'b1) n_done++;
      start = (c < 40) ? c[0] : 1'b0;
      tick();
    end
    start = 1'b0;
    check("pulsed.done_count", n_done, 1);
    check("pulsed.idle", {31'd0, busy}, 32'd0);

    // start held high: back-to-back sweeps with one IDLE cycle between
    start = 1'b1;
    tick();
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("held.first_latency", cyc, SWEEP_LAT);
    tick();
    check("held.idle_gap", {30'd0, busy, done}, 32'd0);
    tick();
    check("held.restart", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("held.second_latency", cyc, SWEEP_LAT);
    start = 1'b0;
    tick();
    check("held.stop", {31'd0, busy}, 32'd0);
    tick();
    check("held.stay_idle", {31'd0, busy}, 32'd0);

    // abort during the SAMPLE of vector 6
    gate_tt  = 16'($urandom);
    e        = 16'($urandom);
    start    = 1'b1;
    expected = e;
    tick();
    start  = 1'b0;
    cyc    = 1;
    target = 6 * (SETTLE + 1) + SETTLE + 1;
    while (cyc < target) begin
      tick();
      cyc++;
    end
    check("abort.at_vec6", {28'd0, dut_in}, 32'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.busy_done", {30'd0, busy, done}, 32'd0);
    check("abort.partial_tt", {16'd0, tt_out}, {16'd0, gate_tt >> 10});
    check("abort.partial_fail", {27'd0, fail_count},
          {27'd0, 5'($countones((gate_tt ^ e) >> 10))});
    check("abort.first_fail", {28'd0, first_fail_idx}, {28'd0, first_mis(gate_tt, e, 6)});
    check("abort.match", {31'd0, match}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    check("abort.no_done", n_done, 0);
    check("abort.tt_held", {16'd0, tt_out}, {16'd0, gate_tt >> 10});
    sweep(e, "after_abort", 1'b0, 1'b0);

    // asynchronous reset during APPLY of vector 9
    gate_tt  = 16'h7176;
    start    = 1'b1;
    expected = 16'h7176;
    tick();
    start  = 1'b0;
    cyc    = 1;
    target = 9 * (SETTLE + 1) + 1;
    while (cyc < target) begin
      tick();
      cyc++;
    end
    check("rst.at_vec9", {28'd0, dut_in}, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.async_clear", {busy, done, dut_in, tt_out, match, fail_count, first_fail_idx}, 32'd0);
    tick();
    check("rst.held_clear", {busy, done, dut_in, tt_out, match, fail_count, first_fail_idx}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("rst.idle_after", {30'd0, busy, done}, 32'd0);
    sweep(16'h7176, "after_reset", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
